// File: rtl/tlb_asid.sv
// Fully associative Sv39 TLB with ASID tagging, mixed 4K/2M/1G pages,
// selective sfence.vma invalidation and invalid-first / round-robin victim choice.
`timescale 1ns/1ps
module tlb_asid #(
   parameter int LG_N   = 3,
   parameter int ASID_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              active,
   input  logic              req,
   input  logic [63:0]       va,
   input  logic [ASID_W-1:0] asid,
   output logic [63:0]       pa,
   output logic              hit,
   output logic              dirty,
   output logic              readable,
   output logic              writable,
   output logic              executable,
   output logic              user,
   input  logic              replace,
   input  logic [63:0]       replace_va,
   input  logic [63:0]       replace_pa,
   input  logic [ASID_W-1:0] replace_asid,
   input  logic [1:0]        replace_level,
   input  logic              replace_global,
   input  logic              replace_dirty,
   input  logic              replace_readable,
   input  logic              replace_writable,
   input  logic              replace_executable,
   input  logic              replace_user,
   input  logic              flush,
   input  logic              flush_va_valid,
   input  logic              flush_asid_valid,
   input  logic [63:0]       flush_va,
   input  logic [ASID_W-1:0] flush_asid,
   output logic [LG_N-1:0]   victim
);

   localparam int N = 2 ** LG_N;

   typedef struct packed {
      logic [26:0]       vpn;
      logic [51:0]       ppn;
      logic [ASID_W-1:0] asid;
      logic [1:0]        level;
      logic              global_pg;
      logic              dirty;
      logic              readable;
      logic              writable;
      logic              executable;
      logic              user;
   } entry_t;

   entry_t          ent [N];
   logic [N-1:0]    valid;
   logic [LG_N-1:0] r_ptr;

   logic [N-1:0]    look_match;
   logic [N-1:0]    flush_kill;
   logic            any_match;
   logic [LG_N-1:0] sel_idx;
   logic            all_valid;
   logic [LG_N-1:0] first_inv;
   logic [63:0]     sel_pa;

   logic unused_bits;
   assign unused_bits = ^{replace_va[63:39], replace_va[11:0], replace_pa[11:0],
                          flush_va[63:39], flush_va[11:0]};

   // Level 3 is reserved and falls through to the 1G comparison
   function automatic logic vpn_eq(input logic [26:0] tag, input logic [1:0] level,
                                   input logic [26:0] vpn);
      logic eq;
      eq = (tag[26:18] == vpn[26:18]);
      if (level == 2'd0 || level == 2'd1) eq = eq && (tag[17:9] == vpn[17:9]);
      if (level == 2'd0) eq = eq && (tag[8:0] == vpn[8:0]);
      return eq;
   endfunction

   function automatic logic [63:0] compose(input logic [51:0] ppn, input logic [1:0] level,
                                           input logic [63:0] addr);
      case (level)
         2'd0:    return {ppn, addr[11:0]};
         2'd1:    return {ppn[51:9], addr[20:0]};
         default: return {ppn[51:18], addr[29:0]};
      endcase
   endfunction

   always_comb begin
      look_match = '0;
      flush_kill = '0;
      for (int unsigned i = 0; i < N; i++) begin
         look_match[i] = valid[i] && (ent[i].global_pg || ent[i].asid == asid) &&
                         vpn_eq(ent[i].vpn, ent[i].level, va[38:12]);
         case ({flush_va_valid, flush_asid_valid})
            2'b11: flush_kill[i] = !ent[i].global_pg && ent[i].asid == flush_asid &&
                                   vpn_eq(ent[i].vpn, ent[i].level, flush_va[38:12]);
            2'b01: flush_kill[i] = !ent[i].global_pg && ent[i].asid == flush_asid;
            2'b10: flush_kill[i] = vpn_eq(ent[i].vpn, ent[i].level, flush_va[38:12]);
            default: flush_kill[i] = 1'b1;
         endcase
      end
   end

   // Lowest-index winner for lookups; lowest-index hole for victim choice
   always_comb begin
      any_match = 1'b0;
      sel_idx   = '0;
      first_inv = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (look_match[i] && !any_match) begin
            any_match = 1'b1;
            sel_idx   = LG_N'(i);
         end
      end
      for (int unsigned i = N; i > 0; i--) begin
         if (!valid[i-1]) first_inv = LG_N'(i - 1);
      end
   end

   assign all_valid = &valid;
   assign victim    = all_valid ? r_ptr : first_inv;
   assign sel_pa    = compose(ent[sel_idx].ppn, ent[sel_idx].level, va);

   // Tag/data storage carries no reset; valid bits alone gate its use
   always_ff @(posedge clk) begin
      if (replace && !flush) begin
         ent[victim].vpn        <= replace_va[38:12];
         ent[victim].ppn        <= replace_pa[63:12];
         ent[victim].asid       <= replace_asid;
         ent[victim].level      <= replace_level;
         ent[victim].global_pg  <= replace_global;
         ent[victim].dirty      <= replace_dirty;
         ent[victim].readable   <= replace_readable;
         ent[victim].writable   <= replace_writable;
         ent[victim].executable <= replace_executable;
         ent[victim].user       <= replace_user;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= '0;
         r_ptr <= '0;
      end else if (flush) begin
         valid <= valid & ~flush_kill;
      end else if (replace) begin
         valid[victim] <= 1'b1;
         if (all_valid) r_ptr <= r_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pa         <= '0;
         hit        <= 1'b0;
         dirty      <= 1'b0;
         readable   <= 1'b0;
         writable   <= 1'b0;
         executable <= 1'b0;
         user       <= 1'b0;
      end else if (!active) begin
         pa         <= va;
         hit        <= 1'b1;
         dirty      <= 1'b1;
         readable   <= 1'b1;
         writable   <= 1'b1;
         executable <= 1'b1;
         user       <= 1'b1;
      end else if (req && any_match) begin
         pa         <= sel_pa;
         hit        <= 1'b1;
         dirty      <= ent[sel_idx].dirty;
         readable   <= ent[sel_idx].readable;
         writable   <= ent[sel_idx].writable;
         executable <= ent[sel_idx].executable;
         user       <= ent[sel_idx].user;
      end else begin
         pa         <= '0;
         hit        <= 1'b0;
         dirty      <= 1'b0;
         readable   <= 1'b0;
         writable   <= 1'b0;
         executable <= 1'b0;
         user       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tlb_asid.sv
// Self-checking bench for tlb_asid: directed scenarios plus randomized traffic
// compared against a shift-and-mask page-table model.
`timescale 1ns/1ps
module tb_tlb_asid;
   localparam int LG_N = 3;
   localparam int ASID_W = 16;
   localparam int N = 8;

   logic clk = 1'b0;
   logic reset, active, req;
   logic [63:0] va;
   logic [ASID_W-1:0] asid;
   logic [63:0] pa;
   logic hit, dirty, readable, writable, executable, user;
   logic replace;
   logic [63:0] replace_va, replace_pa;
   logic [ASID_W-1:0] replace_asid;
   logic [1:0] replace_level;
   logic replace_global, replace_dirty, replace_readable, replace_writable;
   logic replace_executable, replace_user;
   logic flush, flush_va_valid, flush_asid_valid;
   logic [63:0] flush_va;
   logic [ASID_W-1:0] flush_asid;
   logic [LG_N-1:0] victim;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model state
   bit m_valid[N];
   logic [63:0] m_va[N], m_pa[N];
   logic [ASID_W-1:0] m_asid[N];
   int m_lvl[N];
   bit m_g[N];
   logic [4:0] m_perm[N];
   int m_ptr;

   logic exp_hit;
   logic [4:0] exp_perm;
   logic [63:0] exp_pa;
   int exp_victim;

   tlb_asid #(.LG_N(LG_N), .ASID_W(ASID_W)) dut (
      .clk(clk), .reset(reset), .active(active), .req(req), .va(va), .asid(asid),
      .pa(pa), .hit(hit), .dirty(dirty), .readable(readable), .writable(writable),
      .executable(executable), .user(user),
      .replace(replace), .replace_va(replace_va), .replace_pa(replace_pa),
      .replace_asid(replace_asid), .replace_level(replace_level),
      .replace_global(replace_global), .replace_dirty(replace_dirty),
      .replace_readable(replace_readable), .replace_writable(replace_writable),
      .replace_executable(replace_executable), .replace_user(replace_user),
      .flush(flush), .flush_va_valid(flush_va_valid), .flush_asid_valid(flush_asid_valid),
      .flush_va(flush_va), .flush_asid(flush_asid), .victim(victim)
   );

   always #5 clk = ~clk;

   function automatic int page_shift(int lvl);
      return 12 + 9 * ((lvl > 2) ? 2 : lvl);
   endfunction

   function automatic bit same_page(int i, logic [63:0] a);
      logic [38:0] x, y;
      int sh;
      sh = page_shift(m_lvl[i]);
      x = a[38:0];
      y = m_va[i][38:0];
      return (x >> sh) == (y >> sh);
   endfunction

   function automatic int model_victim();
      for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
      return m_ptr;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_ptr = 0;
      exp_victim = 0;
   endtask

   task automatic compute_expected();
      logic [63:0] mask;
      exp_hit = 0; exp_perm = '0; exp_pa = '0;
      if (!active) begin
         exp_hit = 1; exp_perm = '1; exp_pa = va;
      end else if (req) begin
         for (int i = 0; i < N; i++) begin
            if (m_valid[i] && (m_g[i] || m_asid[i] == asid) && same_page(i, va)) begin
               mask = (64'd1 << page_shift(m_lvl[i])) - 64'd1;
               exp_hit = 1;
               exp_perm = m_perm[i];
               exp_pa = (m_pa[i] & ~mask) | (va & mask);
               break;
            end
         end
      end
   endtask

   task automatic model_update();
      int v;
      bit full, vm, am, kill;
      if (flush) begin
         for (int i = 0; i < N; i++) begin
            vm = same_page(i, flush_va);
            am = (m_asid[i] == flush_asid);
            if (flush_va_valid && flush_asid_valid) kill = !m_g[i] && vm && am;
            else if (flush_asid_valid) kill = !m_g[i] && am;
            else if (flush_va_valid) kill = vm;
            else kill = 1;
            if (kill) m_valid[i] = 0;
         end
      end else if (replace) begin
         full = 1;
         for (int i = 0; i < N; i++) if (!m_valid[i]) full = 0;
         v = model_victim();
         m_valid[v] = 1;
         m_va[v] = replace_va;
         m_pa[v] = replace_pa;
         m_asid[v] = replace_asid;
         m_lvl[v] = int'(replace_level);
         m_g[v] = replace_global;
         m_perm[v] = {replace_dirty, replace_readable, replace_writable,
                      replace_executable, replace_user};
         if (full) m_ptr = (m_ptr + 1) % N;
      end
   endtask

   // One clock edge with the inputs currently driven; model follows the same edge
   task automatic step();
      @(posedge clk); #1;
      compute_expected();
      model_update();
      exp_victim = model_victim();
   endtask

   task automatic idle();
      reset = 0; active = 1; req = 0; va = '0; asid = '0;
      replace = 0; replace_va = '0; replace_pa = '0; replace_asid = '0; replace_level = '0;
      replace_global = 0; replace_dirty = 0; replace_readable = 0; replace_writable = 0;
      replace_executable = 0; replace_user = 0;
      flush = 0; flush_va_valid = 0; flush_asid_valid = 0; flush_va = '0; flush_asid = '0;
   endtask

   task automatic set_replace(logic [63:0] v, logic [63:0] p, logic [ASID_W-1:0] a,
                              logic [1:0] lvl, logic g, logic [4:0] perm);
      replace = 1; replace_va = v; replace_pa = p; replace_asid = a; replace_level = lvl;
      replace_global = g;
      {replace_dirty, replace_readable, replace_writable, replace_executable, replace_user} = perm;
   endtask

   task automatic lookup(logic [63:0] v, logic [ASID_W-1:0] a);
      req = 1; va = v; asid = a;
      step();
      req = 0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1; #2;
      model_reset();
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      #1;
      model_reset();
      n_checks++;
      if (hit !== 1'b0 || pa !== 64'd0 || victim !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_async: hit=%b pa=%h victim=%0d want 0/0/0", hit, pa, victim);
      end
      @(negedge clk); reset = 0;
      lookup(64'h1000, 16'd0);
      n_checks++;
      if (hit !== 1'b0 || pa !== 64'd0 || victim !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_first_lookup: hit=%b pa=%h victim=%0d want 0/0/0", hit, pa, victim);
      end
   endtask

   task automatic test_basic_4k();
      set_replace(64'h4000_0000, 64'h8000_0000, 16'd5, 2'd0, 0, 5'b01100);
      step();
      replace = 0;
      lookup(64'h4000_0123, 16'd5);
      n_checks++;
      if (hit !== 1'b1 || pa !== 64'h8000_0123 || writable !== 1'b1 || readable !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_4k_hit: hit=%b pa=%h w=%b r=%b want 1/8000_0123/1/1",
                  hit, pa, writable, readable);
      end
      lookup(64'h4000_0123, 16'd6);
      n_checks++;
      if (hit !== 1'b0 || pa !== 64'd0 || {dirty, readable, writable, executable, user} !== 5'd0) begin
         n_fail++;
         $display("FAIL basic_4k_asid_miss: hit=%b pa=%h want 0/0 perms 0", hit, pa);
      end
   endtask

   task automatic test_global_2m();
      set_replace(64'h0020_0000, 64'h1_0000_0000, 16'd9, 2'd1, 1, 5'b11011);
      step();
      replace = 0;
      lookup(64'h0031_2345, 16'd77);
      n_checks++;
      if (hit !== 1'b1 || pa !== 64'h1_0011_2345) begin
         n_fail++;
         $display("FAIL global_2m_hit: hit=%b pa=%h want 1/1_0011_2345", hit, pa);
      end
      flush = 1; flush_asid_valid = 1; flush_asid = 16'd9;
      step();
      flush = 0; flush_asid_valid = 0;
      lookup(64'h0031_2345, 16'd3);
      n_checks++;
      if (hit !== 1'b1 || pa !== 64'h1_0011_2345) begin
         n_fail++;
         $display("FAIL global_survives_asid_flush: hit=%b pa=%h want 1/1_0011_2345", hit, pa);
      end
      flush = 1; flush_va_valid = 1; flush_va = 64'h0020_0000;
      step();
      flush = 0; flush_va_valid = 0;
      lookup(64'h0031_2345, 16'd3);
      n_checks++;
      if (hit !== 1'b0 || pa !== 64'd0) begin
         n_fail++;
         $display("FAIL global_va_flush: hit=%b pa=%h want 0/0", hit, pa);
      end
   endtask

   task automatic test_fill_wrap();
      pulse_reset();
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (victim !== 3'(i % 8)) begin
            n_fail++;
            $display("FAIL fill_victim_%0d: victim=%0d want %0d", i, victim, i % 8);
         end
         set_replace(64'(i + 1) << 12, 64'(i + 100) << 12, 16'd1, 2'd0, 0, 5'b01000);
         step();
         replace = 0;
      end
      n_checks++;
      if (victim !== 3'd2) begin
         n_fail++;
         $display("FAIL fill_victim_after_wrap: victim=%0d want 2", victim);
      end
      lookup(64'h1abc, 16'd1);
      n_checks++;
      if (hit !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_overwritten_idx0: hit=%b want 0", hit);
      end
      lookup(64'ha456, 16'd1);
      n_checks++;
      if (hit !== 1'b1 || pa !== 64'h6d456) begin
         n_fail++;
         $display("FAIL fill_tenth_entry: hit=%b pa=%h want 1/6d456", hit, pa);
      end
   endtask

   task automatic test_flush_replace();
      flush = 1;
      set_replace(64'h7_7000, 64'h9_9000, 16'd1, 2'd0, 0, 5'b11111);
      step();
      flush = 0; replace = 0;
      n_checks++;
      if (victim !== 3'd0) begin
         n_fail++;
         $display("FAIL flush_replace_victim: victim=%0d want 0", victim);
      end
      lookup(64'h7_7000, 16'd1);
      n_checks++;
      if (hit !== 1'b0 || pa !== 64'd0) begin
         n_fail++;
         $display("FAIL flush_replace_dropped: hit=%b pa=%h want 0/0", hit, pa);
      end
   endtask

   task automatic test_reset_midop();
      set_replace(64'h5000, 64'h6000, 16'd2, 2'd0, 0, 5'b01000);
      step();
      replace = 0;
      lookup(64'h5000, 16'd2);
      n_checks++;
      if (hit !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_precheck: hit=%b want 1", hit);
      end
      req = 1; va = 64'h5000;
      set_replace(64'h8000, 64'h9000, 16'd2, 2'd0, 0, 5'b01000);
      #2 reset = 1; #1;
      model_reset();
      n_checks++;
      if (hit !== 1'b0 || pa !== 64'd0 || readable !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_async_clear: hit=%b pa=%h r=%b want 0/0/0", hit, pa, readable);
      end
      @(posedge clk); #1;
      reset = 0; replace = 0;
      lookup(64'h5000, 16'd2);
      n_checks++;
      if (hit !== 1'b0 || victim !== 3'd0) begin
         n_fail++;
         $display("FAIL midop_first_lookup: hit=%b victim=%0d want 0/0", hit, victim);
      end
   endtask

   task automatic test_bare();
      active = 0; req = 0; va = 64'hDEAD_BEEF;
      step();
      active = 1;
      n_checks++;
      if (hit !== 1'b1 || pa !== 64'hDEAD_BEEF ||
          {dirty, readable, writable, executable, user} !== 5'b11111) begin
         n_fail++;
         $display("FAIL bare_mode: hit=%b pa=%h perms=%b want 1/DEAD_BEEF/11111",
                  hit, pa, {dirty, readable, writable, executable, user});
      end
   endtask

   function automatic logic [63:0] rand_va();
      logic [63:0] a;
      a = {$urandom, $urandom};
      a[38:30] = 9'($urandom_range(0, 1));
      a[29:21] = 9'($urandom_range(0, 1));
      a[20:12] = 9'($urandom_range(0, 3));
      return a;
   endfunction

   task automatic test_random();
      int kind;
      for (int n = 0; n < 400; n++) begin
         idle();
         kind = $urandom_range(0, 9);
         req = 1'($urandom_range(0, 3) != 0);
         va = rand_va();
         asid = 16'($urandom_range(1, 3));
         if (kind >= 4 && kind <= 6 || kind == 8)
            set_replace(rand_va(), {$urandom, $urandom}, 16'($urandom_range(1, 3)),
                        2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                        5'($urandom));
         if (kind == 7 || kind == 8) begin
            flush = 1;
            flush_va_valid = 1'($urandom);
            flush_asid_valid = 1'($urandom);
            flush_va = rand_va();
            flush_asid = 16'($urandom_range(1, 3));
         end
         if (kind == 9) active = 0;
         step();
         n_checks++;
         if ({hit, dirty, readable, writable, executable, user, pa} !== {exp_hit, exp_perm, exp_pa}) begin
            n_fail++;
            $display("FAIL random_lookup[%0d]: hit=%b perms=%b pa=%h want %b/%b/%h", n,
                     hit, {dirty, readable, writable, executable, user}, pa,
                     exp_hit, exp_perm, exp_pa);
         end
         n_checks++;
         if (victim !== 3'(exp_victim)) begin
            n_fail++;
            $display("FAIL random_victim[%0d]: victim=%0d want %0d", n, victim, exp_victim);
         end
      end
      idle();
   endtask

   initial begin
      fork
         begin
            #2_000_000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "timeout");
         end
      join_none
      test_reset();
      test_basic_4k();
      test_global_2m();
      test_fill_wrap();
      test_flush_replace();
      test_reset_midop();
      test_bare();
      pulse_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
